ex_muldiv_sequencer: RTL and testbench
======================================

// Module: ex_muldiv_sequencer
// PURPOSE
// - EX-stage consumer of the ID/EX pipeline register outputs. Executes RV32M ops
//   (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively.
// - Drives stall to freeze ID/EX and upstream registers (their wren = ~stall) until the result is ready.
// - Presents a one-cycle result_valid for the EX/MEM writeback mux. Non-M operators pass untouched, stall=0.
// PARAMETERS
// - XLEN   32   operand/result width
// - ITERS  32   iteration cycles per mul/div; must equal XLEN
// PORTS
// - clk              in   1     system clock, rising edge
// - reset_n          in   1     synchronous, active-low reset; the only reset in the block
// - alu_rd_operator  in   5     from ID/EX; M ops encoded per muldiv_pkg
// - rs1_data         in   XLEN  from ID/EX; dividend / multiplicand
// - rs2_data         in   XLEN  from ID/EX; divisor / multiplier
// - stall            out  1     1 = hold ID/EX and earlier stages (combinational)
// - result_valid     out  1     1 for exactly one cycle when result holds the M-op answer
// - result           out  XLEN  M-op result; stable from DONE until the next op starts
// BEHAVIOUR
// - Reset (reset_n=0 at posedge clk): state=IDLE, result=0, result_valid=0, internal regs 0. stall=0 follows the same cycle.
// - is_m = operator in OP_MUL..OP_REMU (5'd16..5'd23). Operator 0, the ID/EX reset/bubble value, is never M.
// - FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: is_m=1 latches op, operand magnitudes and sign flags -> RUN, counter=0.
//         Div special case -> DONE directly.
//   RUN: one mul shift-add or div restoring step per cycle; counter+1; counter==ITERS-1 -> DONE.
//   DONE: result registered, result_valid=1 -> IDLE unconditionally.
// - stall = is_m & (state!=DONE). Pipeline advances on the DONE edge.
//   A back-to-back M op arrives while IDLE and starts next cycle; no missed or duplicated ops.
// - Latency: op visible in cycle 0; RUN in cycles 1..32; DONE and result_valid in cycle 33; stall high in cycles 0..32.
// - Mul: 2*XLEN product of magnitudes, then negated when the sign flags differ.
//   MUL takes [31:0]; MULH/MULHSU/MULHU take [63:32].
//   MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
// - Div/rem: restoring division on magnitudes.
//   Quotient negated if the signs differ (signed ops). Remainder takes the sign of the dividend.
// - Special cases (IDLE -> DONE, result_valid in cycle 1, stall cycle 0 only):
//   divisor==0: DIV/DIVU -> all-ones, REM/REMU -> rs1.
//   signed overflow rs1=0x80000000, rs2=-1: DIV -> 0x80000000, REM -> 0.
// - Operands are latched in IDLE. ID/EX is frozen anyway, but input changes during RUN are ignored.
// - reset_n low mid-RUN: abort at that edge. No result_valid. Next cycle behaves as after power-up.
// - All arithmetic is unsigned on magnitudes. Negation is two's complement at XLEN or 2*XLEN. No X-propagation from unused regs.
// STRUCTURE
// - muldiv_pkg: OP_MUL..OP_REMU localparams (5'd16..5'd23), typedef enum logic[1:0] {IDLE,RUN,DONE} muldiv_state_t,
//   and a function is_m_op(). The ID decoder imports the same package.
// - Sub-module radix2_divider (start, dividend, divisor -> quotient, remainder, done).
//   Kept separate for reuse.
// - Multiply shift-add datapath and sign fix-up live inline. Counter width is $clog2(ITERS)+1.
// TESTING
// - MUL 7 * -3: result=0xFFFFFFEB, result_valid in cycle 33, stall high cycles 0..32 only.
// - MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE;
//   MULHSU -1 * 0xFFFFFFFF -> 0xFFFFFFFF.
// - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
// - DIV x/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both in cycle 1.
//   DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
// - Back-to-back MUL then DIVU with no bubble: two result_valid pulses 34 cycles apart, each with the correct value.
//   Non-M op (operator 0): stall=0 and result_valid=0 throughout.
// - reset_n low at RUN cycle 10 -> state IDLE, result 0, no result_valid.
//   Re-issue the op after reset -> correct result 33 cycles later.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared RV32M operator encodings and sequencer state type.
// Imported by the ID decoder and by the EX-stage mul/div sequencer.
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_m_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/radix2_divider.sv
// Unsigned restoring divider, one quotient bit per step.
// quotient/remainder show the post-step values so the caller can register the answer on the final edge.
module radix2_divider #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CW = $clog2(ITERS) + 1;

  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   shifted, diff;
  logic            ge;

  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign diff      = shifted - {1'b0, dvsr_q};
  assign ge        = ~diff[XLEN];
  assign remainder = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quotient  = {quo_q[XLEN-2:0], ge};
  assign done      = step && (cnt_q == CW'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvsr_q <= divisor;
      cnt_q  <= '0;
    end else if (step) begin
      rem_q  <= remainder;
      quo_q  <= quotient;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage iterative RV32M unit: stalls ID/EX while a mul/div runs on operand magnitudes,
// then presents a one-cycle result_valid with the sign-corrected result.
module ex_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [4:0]      alu_rd_operator,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITERS) + 1;

  muldiv_state_t     state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              neg_q, neg_d, negr_q, negr_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_m, rs1_signed, rs2_signed, s1, s2;
  logic [XLEN-1:0]   mag1, mag2, special_val;
  logic              div_zero, div_ovf, special;
  logic              div_start, div_step, div_done, last_step;
  logic [XLEN-1:0]   div_quo, div_rem, quo_fix, rem_fix, mul_res, div_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_n, prod_fix;

  assign is_m       = is_m_op(alu_rd_operator);
  assign rs1_signed = (alu_rd_operator == OP_MUL) || (alu_rd_operator == OP_MULH) ||
                      (alu_rd_operator == OP_MULHSU) || (alu_rd_operator == OP_DIV) ||
                      (alu_rd_operator == OP_REM);
  assign rs2_signed = (alu_rd_operator == OP_MUL) || (alu_rd_operator == OP_MULH) ||
                      (alu_rd_operator == OP_DIV) || (alu_rd_operator == OP_REM);
  assign s1   = rs1_signed & rs1_data[XLEN-1];
  assign s2   = rs2_signed & rs2_data[XLEN-1];
  assign mag1 = s1 ? -rs1_data : rs1_data;
  assign mag2 = s2 ? -rs2_data : rs2_data;

  // Divide-by-zero and INT_MIN/-1 bypass the iteration entirely.
  assign div_zero = (rs2_data == '0);
  assign div_ovf  = ((alu_rd_operator == OP_DIV) || (alu_rd_operator == OP_REM)) &&
                    (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign special  = is_div_op(alu_rd_operator) && (div_zero || div_ovf);
  always_comb begin
    special_val = '0;
    if (div_zero)
      special_val = ((alu_rd_operator == OP_DIV) || (alu_rd_operator == OP_DIVU)) ? '1 : rs1_data;
    else if (alu_rd_operator == OP_DIV)
      special_val = rs1_data;
  end

  assign div_start = (state_q == IDLE) && is_m && is_div_op(alu_rd_operator) && !special;
  assign div_step  = (state_q == RUN) && is_div_op(op_q);

  radix2_divider #(.XLEN(XLEN), .ITERS(ITERS)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .step      (div_step),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Right-shifting shift-add: multiplier starts in the low half and is consumed LSB first.
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
  assign prod_n   = {mul_sum, prod_q[XLEN-1:1]};
  assign prod_fix = neg_q ? -prod_n : prod_n;
  assign mul_res  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign quo_fix  = neg_q ? -div_quo : div_quo;
  assign rem_fix  = negr_q ? -div_rem : div_rem;
  assign div_res  = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo_fix : rem_fix;

  assign last_step = is_div_op(op_q) ? div_done : (cnt_q == CW'(ITERS - 1));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (is_m) begin
          op_d    = alu_rd_operator;
          cnt_d   = '0;
          neg_d   = s1 ^ s2;
          negr_d  = s1;
          mcand_d = mag1;
          prod_d  = {{XLEN{1'b0}}, mag2};
          if (special) begin
            result_d = special_val;
            state_d  = DONE;
          end else begin
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (!is_div_op(op_q)) prod_d = prod_n;
        if (last_step) begin
          result_d = is_div_op(op_q) ? div_res : mul_res;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign stall        = is_m && (state_q != DONE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer: a driver models the ID/EX register honouring stall,
// a monitor checks every result_valid pulse against expected value and arrival cycle.
module tb_ex_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        stall, rv;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] val;
    int          at;
  } exp_t;
  exp_t sb[$];

  ex_muldiv_sequencer #(.XLEN(32), .ITERS(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .alu_rd_operator (op),
    .rs1_data        (a),
    .rs2_data        (b),
    .stall           (stall),
    .result_valid    (rv),
    .result          (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference semantics from the RV32M rules, using native 64-bit and int arithmetic.
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    longint      uy = longint'({32'b0, y});
    int          ix = x;
    int          iy = y;
    logic [63:0] p;
    case (o)
      5'd16: begin p = sx * sy; return p[31:0]; end
      5'd17: begin p = sx * sy; return p[63:32]; end
      5'd18: begin p = sx * uy; return p[63:32]; end
      5'd19: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      5'd20: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ix / iy;
      end
      5'd21: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd22: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return ix % iy;
      end
      5'd23: return (y == 0) ? x : x % y;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int latency(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o < 5'd16 || o > 5'd23) return 0;
    if (o >= 5'd20 && y == 0) return 1;
    if ((o == 5'd20 || o == 5'd22) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present one op at ID/EX, hold it while stall is expected, advance after the release edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    int   lat;
    int   bad;
    exp_t e;
    op  = o;
    a   = x;
    b   = y;
    lat = latency(o, x, y);
    if (lat > 0) begin
      e.val = model(o, x, y);
      e.at  = cyc + lat;
      sb.push_back(e);
    end
    bad = 0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (stall !== (k < lat)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_profile op=%0d: %0d wrong cycles, required high for %0d cycles then low", o, bad, lat);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rv !== 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: result_valid=%b result=%h with nothing pending (cycle %0d)", rv, result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.val);
        check("valid_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    op = 5'd0;
    a  = 32'h0;
    b  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_valid", {31'b0, rv}, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;

    // Directed cases, issued back-to-back with no bubbles.
    issue(OP_MUL,    32'd7,          32'hFFFF_FFFD);
    issue(OP_MULH,   32'h8000_0000,  32'h8000_0000);
    issue(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    issue(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    issue(OP_DIV,    32'hFFFF_FFF9,  32'd2);
    issue(OP_REM,    32'hFFFF_FFF9,  32'd2);
    issue(OP_MUL,    32'd12345,      32'd678);
    issue(OP_DIVU,   32'd100,        32'd7);
    op = 5'd0;
    @(negedge clk);
    check("result_hold", result, 32'd14);
    @(posedge clk);
    #1;
    issue(OP_REMU,   32'd100,        32'd7);
    issue(OP_DIV,    32'd1234,       32'd0);
    issue(OP_REM,    32'd5,          32'd0);
    issue(OP_DIVU,   32'd9,          32'd0);
    issue(OP_REMU,   32'd9,          32'd0);
    issue(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
    issue(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF);
    issue(OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF);

    // Non-M operators never stall or produce a result.
    for (int i = 0; i < 6; i++) issue(5'd0, $urandom, $urandom);
    issue(5'd15, $urandom, $urandom);
    issue(5'd24, $urandom, $urandom);

    // Reset in the middle of RUN aborts the op; the re-issued op completes normally.
    op = OP_MUL;
    a  = 32'd123;
    b  = 32'hFFFF_FF00;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    op = 5'd0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_result", result, 32'h0);
    check("abort_valid", {31'b0, rv}, 32'h0);
    check("abort_stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;
    issue(OP_MUL, 32'd123, 32'hFFFF_FF00);

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  o;
      logic [31:0] x, y;
      o = 5'(16 + $urandom_range(0, 7));
      x = $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'h0;
        1:       y = 32'($urandom_range(1, 50));
        2:       begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      issue(o, x, y);
    end

    op = 5'd0;
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
